// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared types and clamp-limit helpers for the es1 SPU arithmetic ops.
package elixirchip_es1_spu_pkg;

  typedef logic signed [63:0] spu_wide_t;
  typedef logic        [7:0]  spu_shift_t;

  // Largest value a signed field of the given width can hold.
  function automatic spu_wide_t spu_sat_hi(input int unsigned bits);
    return (spu_wide_t'(1) <<< (bits - 1)) - spu_wide_t'(1);
  endfunction

  function automatic spu_wide_t spu_sat_lo(input int unsigned bits);
    return -(spu_wide_t'(1) <<< (bits - 1));
  endfunction

  function automatic spu_shift_t spu_clip_shift(input spu_shift_t sh, input spu_shift_t lim);
    return (sh > lim) ? lim : sh;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// Clock-enabled delay line; DEPTH=0 is a plain wire.
module elixirchip_es1_spu_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             reset,
  input  logic             clk,
  input  logic             cke,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_data = i_data;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pipe [DEPTH];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else if (cke) begin
          r_pipe[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_data = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/elixirchip_es1_spu_op_sra_rnd_sat.sv
// Arithmetic right shift with round-half-up and signed saturation,
// plus a sticky count of saturated results.
module elixirchip_es1_spu_op_sra_rnd_sat
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int                  LATENCY    = 2,
  parameter int                  DATA_BITS  = 8,
  parameter int                  OUT_BITS   = 4,
  parameter int                  MAX_SHIFT  = DATA_BITS,
  parameter int                  SHIFT_BITS = $clog2(MAX_SHIFT + 1),
  parameter logic [OUT_BITS-1:0] CLEAR_DATA = '0,
  parameter int                  CNT_BITS   = 16,
  parameter                      DEVICE     = "RTL",
  parameter                      SIMULATION = "false",
  parameter                      DEBUG      = "false"
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  logic [SHIFT_BITS-1:0] s_shift,
  input  logic [DATA_BITS-1:0]  s_data,
  input  logic                  s_clear,
  input  logic                  s_valid,
  output logic [OUT_BITS-1:0]   m_data,
  output logic                  m_sat,
  output logic [CNT_BITS-1:0]   m_sat_count
);

  localparam int SUM_BITS = DATA_BITS + 1;
  localparam int DLY_BITS = OUT_BITS + 3;
  localparam int DLY_DEPTH = (LATENCY >= 2) ? LATENCY - 2 : 0;

  localparam logic signed [SUM_BITS-1:0] LIM_HI = SUM_BITS'(spu_sat_hi(OUT_BITS));
  localparam logic signed [SUM_BITS-1:0] LIM_LO = SUM_BITS'(spu_sat_lo(OUT_BITS));

  logic        [SHIFT_BITS-1:0] w_shift;
  logic signed [SUM_BITS-1:0]   w_ext;
  logic signed [SUM_BITS-1:0]   w_rnd;
  logic signed [SUM_BITS-1:0]   w_sum;

  assign w_shift = SHIFT_BITS'(spu_clip_shift(spu_shift_t'(s_shift), spu_shift_t'(MAX_SHIFT)));
  assign w_ext   = {s_data[DATA_BITS-1], s_data};
  assign w_rnd   = (w_shift == '0) ? '0
                 : ({{(SUM_BITS-1){1'b0}}, 1'b1} << (w_shift - 1'b1));
  assign w_sum   = w_ext + w_rnd;

  logic signed [SUM_BITS-1:0]   w_s1_sum;
  logic        [SHIFT_BITS-1:0] w_s1_shift;
  logic                         w_s1_valid;
  logic                         w_s1_clear;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign w_s1_sum   = w_sum;
      assign w_s1_shift = w_shift;
      assign w_s1_valid = s_valid;
      assign w_s1_clear = s_clear;
    end else begin : g_stage1
      logic signed [SUM_BITS-1:0]   r_sum;
      logic        [SHIFT_BITS-1:0] r_shift;
      logic                         r_valid;
      logic                         r_clear;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sum   <= '0;
          r_shift <= '0;
          r_valid <= 1'b0;
          r_clear <= 1'b0;
        end else if (cke) begin
          r_sum   <= w_sum;
          r_shift <= w_shift;
          r_valid <= s_valid;
          r_clear <= s_clear;
        end
      end

      assign w_s1_sum   = r_sum;
      assign w_s1_shift = r_shift;
      assign w_s1_valid = r_valid;
      assign w_s1_clear = r_clear;
    end
  endgenerate

  logic signed [SUM_BITS-1:0] w_shr;
  logic                       w_over;
  logic                       w_under;
  logic        [OUT_BITS-1:0] w_res;
  logic                       w_sat;

  assign w_shr   = w_s1_sum >>> w_s1_shift;
  assign w_over  = (w_shr > LIM_HI);
  assign w_under = (w_shr < LIM_LO);
  assign w_sat   = w_over | w_under;
  assign w_res   = w_over  ? LIM_HI[OUT_BITS-1:0]
                 : w_under ? LIM_LO[OUT_BITS-1:0]
                 : w_shr[OUT_BITS-1:0];

  logic [DLY_BITS-1:0] w_dly_in;
  logic [DLY_BITS-1:0] w_dly_out;

  assign w_dly_in = {w_res, w_sat, w_s1_valid, w_s1_clear};

  elixirchip_es1_spu_delay #(
    .WIDTH (DLY_BITS),
    .DEPTH (DLY_DEPTH)
  ) u_delay (
    .reset  (reset),
    .clk    (clk),
    .cke    (cke),
    .i_data (w_dly_in),
    .o_data (w_dly_out)
  );

  logic [OUT_BITS-1:0] w_o_res;
  logic                w_o_sat;
  logic                w_o_valid;
  logic                w_o_clear;

  assign {w_o_res, w_o_sat, w_o_valid, w_o_clear} = w_dly_out;

  logic [OUT_BITS-1:0] r_data;
  logic                r_sat;
  logic [CNT_BITS-1:0] r_sat_count;

  // Clear wins over valid; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data      <= CLEAR_DATA;
      r_sat       <= 1'b0;
      r_sat_count <= '0;
    end else if (cke) begin
      if (w_o_clear) begin
        r_data      <= CLEAR_DATA;
        r_sat       <= 1'b0;
        r_sat_count <= '0;
      end else if (w_o_valid) begin
        r_data <= w_o_res;
        r_sat  <= w_o_sat;
        if (w_o_sat && (r_sat_count != '1)) r_sat_count <= r_sat_count + CNT_BITS'(1);
      end
    end
  end

  assign m_data      = r_data;
  assign m_sat       = r_sat;
  assign m_sat_count = r_sat_count;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_sra_rnd_sat.sv
// Randomized and directed bench for the rounding/saturating right shifter.
module tb_elixirchip_es1_spu_op_sra_rnd_sat;

  localparam int LAT = 2;

  logic       reset;
  logic       clk;
  logic       cke;
  logic [3:0] s_shift;
  logic [7:0] s_data;
  logic       s_clear;
  logic       s_valid;
  logic [3:0] m_data;
  logic       m_sat;
  logic [15:0] m_sat_count;

  elixirchip_es1_spu_op_sra_rnd_sat dut (
    .reset       (reset),
    .clk         (clk),
    .cke         (cke),
    .s_shift     (s_shift),
    .s_data      (s_data),
    .s_clear     (s_clear),
    .s_valid     (s_valid),
    .m_data      (m_data),
    .m_sat       (m_sat),
    .m_sat_count (m_sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit cl;
    int res;
    bit sat;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  exp_data;
  logic        exp_sat;
  logic [15:0] exp_cnt;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor((d + 2^(sh-1)) / 2^sh) with true floor division, then clamp.
  task automatic ref_calc(input int d, input int sh_in, output int res, output bit sat);
    int sh, p, num, qt, r;
    sh = (sh_in > 8) ? 8 : sh_in;
    if (sh == 0) r = d;
    else begin
      p   = 1 << sh;
      num = d + p / 2;
      qt  = num / p;
      if ((num % p != 0) && (num < 0)) qt = qt - 1;
      r = qt;
    end
    sat = 1'b0;
    if (r > 7)  begin r = 7;  sat = 1'b1; end
    if (r < -8) begin r = -8; sat = 1'b1; end
    res = r;
  endtask

  task automatic model_reset();
    q.delete();
    exp_data = 4'h0;
    exp_sat  = 1'b0;
    exp_cnt  = 16'h0;
  endtask

  task automatic model_edge(input bit c, input bit v, input bit cl, input int d, input int sh);
    ent_t e;
    if (!c) return;
    e.v  = v;
    e.cl = cl;
    ref_calc(d, sh, e.res, e.sat);
    q.push_back(e);
    if (q.size() >= LAT) begin
      e = q.pop_front();
      if (e.cl) begin
        exp_data = 4'h0;
        exp_sat  = 1'b0;
        exp_cnt  = 16'h0;
      end else if (e.v) begin
        exp_data = e.res[3:0];
        exp_sat  = e.sat;
        if (e.sat && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".m_data"}, 32'(m_data), 32'(exp_data));
    chk({tag, ".m_sat"}, 32'(m_sat), 32'(exp_sat));
    chk({tag, ".m_sat_count"}, 32'(m_sat_count), 32'(exp_cnt));
  endtask

  task automatic step(input bit c, input bit v, input bit cl, input logic [7:0] d, input logic [3:0] sh);
    cke = c; s_valid = v; s_clear = cl; s_data = d; s_shift = sh;
    @(posedge clk);
    #1;
    model_edge(c, v, cl, int'($signed(d)), int'(sh));
    check_outputs("step");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    cke = 1'b0; s_valid = 1'b0; s_clear = 1'b0; s_data = 8'h0; s_shift = 4'h0;
    model_reset();
    #12;
    chk("reset.m_data", 32'(m_data), 32'h0);
    chk("reset.m_sat", 32'(m_sat), 32'h0);
    chk("reset.m_sat_count", 32'(m_sat_count), 32'h0);
    #5 reset = 1'b0;

    // 0x17 >> 2 rounds to 6
    step(1, 1, 0, 8'h17, 4'd2);
    step(1, 0, 0, 8'h00, 4'd0);
    chk("d17_s2.m_data", 32'(m_data), 32'h6);
    chk("d17_s2.m_sat", 32'(m_sat), 32'h0);

    // -23 >> 2 floors to -6, then hold with valid low
    step(1, 1, 0, 8'hE9, 4'd2);
    step(1, 0, 0, 8'h55, 4'd1);
    chk("dE9_s2.m_data", 32'(m_data), 32'hA);
    step(1, 0, 0, 8'h7F, 4'd0);
    step(1, 0, 0, 8'h80, 4'd0);
    chk("hold.m_data", 32'(m_data), 32'hA);

    // Full-width shift and an over-range shift both give zero
    step(1, 1, 0, 8'h7F, 4'd8);
    step(1, 1, 0, 8'h80, 4'd15);
    chk("s8.m_data", 32'(m_data), 32'h0);
    step(1, 0, 0, 8'h00, 4'd0);
    chk("s15.m_data", 32'(m_data), 32'h0);

    // Positive and negative saturation
    step(1, 1, 0, 8'h7F, 4'd1);
    step(1, 1, 0, 8'h80, 4'd0);
    chk("d7F_s1.m_data", 32'(m_data), 32'h7);
    chk("d7F_s1.m_sat", 32'(m_sat), 32'h1);
    chk("d7F_s1.m_sat_count", 32'(m_sat_count), 32'h1);
    step(1, 0, 0, 8'h00, 4'd0);
    chk("d80_s0.m_data", 32'(m_data), 32'h8);
    chk("d80_s0.m_sat", 32'(m_sat), 32'h1);
    chk("d80_s0.m_sat_count", 32'(m_sat_count), 32'h2);

    // Clear beats valid
    step(1, 1, 1, 8'h7F, 4'd0);
    step(1, 0, 0, 8'h00, 4'd0);
    chk("clear.m_data", 32'(m_data), 32'h0);
    chk("clear.m_sat_count", 32'(m_sat_count), 32'h0);

    // cke drop for three cycles with an operand in flight
    step(1, 1, 0, 8'h17, 4'd2);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'($urandom), 4'($urandom_range(0, 15)));
    chk("cke_hold.m_data", 32'(m_data), 32'h0);
    step(1, 0, 0, 8'h00, 4'd0);
    chk("cke_realign.m_data", 32'(m_data), 32'h6);

    // Randomized stream against the reference model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
           8'($urandom), 4'($urandom_range(0, 15)));
    end

    // Reset with operands in flight
    step(1, 1, 0, 8'h7F, 4'd0);
    step(1, 1, 0, 8'h7F, 4'd0);
    cke = 1'b1; s_valid = 1'b1; s_clear = 1'b0; s_data = 8'h80; s_shift = 4'd0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_mid.m_data", 32'(m_data), 32'h0);
    chk("rst_mid.m_sat", 32'(m_sat), 32'h0);
    chk("rst_mid.m_sat_count", 32'(m_sat_count), 32'h0);
    s_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 4'd0);
    chk("rst_after.m_data", 32'(m_data), 32'h0);
    chk("rst_after.m_sat_count", 32'(m_sat_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
